// File: rtl/seg_scan_mux_pkg.sv
// seg_scan_mux_pkg: shared constants and types for the 7-segment scanner.
//   - default ON / GUARD phase lengths
//   - scan FSM state encoding
//   - anode-off level (common-anode, active-low enables)
package seg_scan_mux_pkg;

    localparam int DEF_ON_CYCLES    = 50000;
    localparam int DEF_GUARD_CYCLES = 500;

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_ON    = 1'b1
    } scan_state_e;

    // One anode bit in its "off" level; replicate to NUM_DIGITS for all-off.
    localparam logic AN_OFF = 1'b1;

endpackage

// File: rtl/seg_scan_phase_cnt.sv
// seg_scan_phase_cnt: terminal-count counter for the scanner phases.
//   clk, rst : clock, synchronous active-high reset (clears the count)
//   limit    : terminal value (phase length - 1), may change every cycle
//   cnt      : current count, 0..limit
//   tc       : high while cnt == limit; the counter clears on that edge
module seg_scan_phase_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    assign tc = (cnt == limit);

    always_ff @(posedge clk) begin
        if (rst || tc)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed scanner for a common-anode 7-segment display.
// Each digit gets GUARD_CYCLES with all anodes off (bin already showing the
// digit) followed by ON_CYCLES with its anode driven. The displayed value is
// snapshotted during digit 0's guard so a frame never mixes two values.
//   clk, rst   : clock, synchronous active-high reset
//   value      : 4*NUM_DIGITS, digit 0 = value[3:0] (rightmost)
//   blank      : per-digit forced blank (1 = anode held off)
//   bin        : nibble of the scanned digit, to the segment decoder
//   an_n       : active-low anode enables, at most one low
//   digit_idx  : digit being scanned
//   frame_done : one-cycle pulse after the last digit's ON phase
// Optional: define SEG_LEADING_ZERO_BLANK_EN to auto-blank leading zeros
// (digit k>=1 is dark when shadow nibbles k..NUM_DIGITS-1 are all zero).
module seg_scan_mux
    import seg_scan_mux_pkg::*;
#(
    parameter  int NUM_DIGITS   = 4,
    parameter  int ON_CYCLES    = DEF_ON_CYCLES,
    parameter  int GUARD_CYCLES = DEF_GUARD_CYCLES,
    parameter  int CNT_W        = 16,
    localparam int DW           = $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   blank,
    output logic [3:0]              bin,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic [DW-1:0]           digit_idx,
    output logic                    frame_done
);

    localparam logic [CNT_W-1:0] GUARD_LIM = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] ON_LIM    = CNT_W'(ON_CYCLES - 1);
    localparam logic [DW-1:0]    LAST_IDX  = DW'(NUM_DIGITS - 1);

    scan_state_e             state;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [CNT_W-1:0]        limit;
    logic [CNT_W-1:0]        cnt;
    logic                    tc;
    logic [NUM_DIGITS-1:0]   lz_blank;

    assign limit = (state == ST_GUARD) ? GUARD_LIM : ON_LIM;

    seg_scan_phase_cnt #(.CNT_W(CNT_W)) u_phase (
        .clk   (clk),
        .rst   (rst),
        .limit (limit),
        .cnt   (cnt),
        .tc    (tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_GUARD;
            digit_idx  <= '0;
            shadow     <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // Held open for all of digit 0's guard, so the last sample wins.
            if (state == ST_GUARD && digit_idx == '0)
                shadow <= value;
            if (tc) begin
                case (state)
                    ST_GUARD: state <= ST_ON;
                    ST_ON: begin
                        state      <= ST_GUARD;
                        // Explicit wrap keeps non-power-of-2 counts in range.
                        digit_idx  <= (digit_idx == LAST_IDX) ? '0 : digit_idx + DW'(1);
                        frame_done <= (digit_idx == LAST_IDX);
                    end
                    default: state <= ST_GUARD;
                endcase
            end
        end
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic lz_run;

    // Walk down from the top digit; a digit is dark while everything at and
    // above it is zero. Digit 0 is never included.
    always_comb begin
        lz_run   = 1'b1;
        lz_blank = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            lz_run      = lz_run & (shadow[4*k +: 4] == 4'h0);
            lz_blank[k] = lz_run;
        end
    end
`else
    assign lz_blank = '0;
`endif

    always_comb begin
        bin  = '0;
        an_n = {NUM_DIGITS{AN_OFF}};
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digit_idx == DW'(k)) begin
                bin = shadow[4*k +: 4];
                if (state == ST_ON && !blank[k] && !lz_blank[k])
                    an_n[k] = ~AN_OFF;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
module tb_seg_scan_mux;

    localparam int N     = 4;
    localparam int O     = 3;
    localparam int G     = 1;
    localparam int SLOT  = G + O;
    localparam int FRAME = N * SLOT;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  blank;
    logic [3:0]  bin;
    logic [3:0]  an_n;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    // model: cycles since reset and the value latched for the current frame
    int          mc      = 0;
    logic [15:0] msh     = '0;
    bit          started = 0;

    seg_scan_mux #(
        .NUM_DIGITS  (N),
        .ON_CYCLES   (O),
        .GUARD_CYCLES(G),
        .CNT_W       (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .blank      (blank),
        .bin        (bin),
        .an_n       (an_n),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // highest digit holding a nonzero nibble (0 when the whole value is zero)
    function automatic int top_nz(input logic [15:0] v);
        int h = 0;
        for (int k = 0; k < N; k++)
            if (v[4*k +: 4] != 4'h0) h = k;
        return h;
    endfunction

    // Model update on each edge, then compare shortly after it.
    always @(posedge clk) begin
        int p, slot;
        logic       lit;
        logic [3:0] e_an;
        if (rst) begin
            mc = 0; msh = '0; started = 1;
        end else if (started) begin
            if ((mc % FRAME) < G) msh = value;
            mc++;
        end
        #1;
        if (started) begin
            p    = mc % FRAME;
            slot = p / SLOT;
            lit  = ((p % SLOT) >= G) && !blank[slot];
`ifdef SEG_LEADING_ZERO_BLANK_EN
            if (slot > top_nz(msh)) lit = 1'b0;
`endif
            e_an = 4'hF;
            if (lit) e_an[slot] = 1'b0;
            chk("m_an_n", 32'(an_n), 32'(e_an));
            chk("m_bin", 32'(bin), 32'(msh[4*slot +: 4]));
            chk("m_idx", 32'(digit_idx), 32'(slot));
            chk("m_frame_done", 32'(frame_done), 32'(p == 0 && mc != 0));
        end
    end

    // Advance to the cycle at frame position slot*SLOT+off (bounded).
    task automatic goto(input int slot, input int off);
        int tgt = slot * SLOT + off;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if ((mc % FRAME) == tgt) return;
        end
        chk("goto_timeout", 32'(mc % FRAME), 32'(tgt));
    endtask

    initial begin
        rst = 1'b1; value = 16'h1234; blank = 4'b0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_an_n", 32'(an_n), 32'hF);
        chk("rst_bin", 32'(bin), 32'h0);
        chk("rst_idx", 32'(digit_idx), 32'h0);
        chk("rst_fd", 32'(frame_done), 32'h0);
        rst = 1'b0;

        @(negedge clk);
        chk("d0_an", 32'(an_n), 32'hE);
        chk("d0_bin", 32'(bin), 32'h4);
        goto(1, G);
        chk("d1_an", 32'(an_n), 32'hD);
        chk("d1_bin", 32'(bin), 32'h3);
        goto(0, 0);
        chk("fd_pulse", 32'(frame_done), 32'h1);
        chk("fd_bin", 32'(bin), 32'h4);

        // change mid-frame: must not reach digits 2,3 until next frame
        goto(2, G);
        value = 16'hABCD;
        chk("snap_d2", 32'(bin), 32'h2);
        goto(3, G);
        chk("snap_d3", 32'(bin), 32'h1);
        chk("snap_an3", 32'(an_n), 32'h7);
        goto(0, G);
        chk("next_d0", 32'(bin), 32'hD);
        chk("next_an0", 32'(an_n), 32'hE);

        blank = 4'b0100;
        goto(2, G);
        chk("blank_an", 32'(an_n), 32'hF);
        chk("blank_bin", 32'(bin), 32'hB);
        goto(3, G);
        chk("blank_an3", 32'(an_n), 32'h7);
        chk("blank_bin3", 32'(bin), 32'hA);

        // reset during digit 3 ON
        goto(3, G + 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_an", 32'(an_n), 32'hF);
        chk("mrst_idx", 32'(digit_idx), 32'h0);
        chk("mrst_fd", 32'(frame_done), 32'h0);
        value = 16'h0070; blank = 4'b0000; rst = 1'b0;
        @(negedge clk);
        chk("lz_d0_bin", 32'(bin), 32'h0);
        chk("lz_d0_an", 32'(an_n), 32'hE);
        goto(1, G);
        chk("lz_d1_bin", 32'(bin), 32'h7);
        chk("lz_d1_an", 32'(an_n), 32'hD);
        goto(2, G);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        chk("lz_d2_an", 32'(an_n), 32'hF);
`else
        chk("lz_d2_an", 32'(an_n), 32'hB);
`endif
        goto(3, G);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        chk("lz_d3_an", 32'(an_n), 32'hF);
`else
        chk("lz_d3_an", 32'(an_n), 32'h7);
`endif
        value = 16'h0000;
        goto(0, G);
        chk("z_d0_bin", 32'(bin), 32'h0);
        chk("z_d0_an", 32'(an_n), 32'hE);
        goto(1, G);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        chk("z_d1_an", 32'(an_n), 32'hF);
`else
        chk("z_d1_an", 32'(an_n), 32'hD);
`endif
        repeat (2 * FRAME) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
